// File: rtl/uart_rx_buffer.sv
// UART 8N1 receiver with a byte-wide receive buffer and register interface.
// Define UART_RX_FIFO_EN for a 2^DEPTH_LOG2 FIFO; otherwise a single holding register is used.
module uart_rx_buffer #(
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter logic [31:0] DIV_RESET  = 32'd868
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ser_rx,
  input  logic [3:0]  reg_div_we,
  input  logic [31:0] reg_div_di,
  output logic [31:0] reg_div_do,
  input  logic        reg_dat_re,
  output logic [31:0] reg_dat_do,
  input  logic        reg_sta_we,
  output logic [31:0] reg_sta_do,
  output logic        empty
);

  localparam int unsigned CntW = DEPTH_LOG2 + 1;

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e         r_state, w_state_next;
  logic [1:0]     r_sync;
  logic [31:0]    r_div, r_div_lat, r_cnt;
  logic [2:0]     r_bit;
  logic [7:0]     r_shift;
  logic           r_brk;
  logic           r_ovr, r_ferr;
  logic           w_rx, w_expire;
  logic [31:0]    w_div_eff;
  logic           w_push, w_ferr_set;
  logic           w_wr, w_rd, w_ovr_set;
  logic           w_empty, w_full;
  logic [7:0]     w_head;
  logic [CntW-1:0] w_count;

  assign w_rx      = r_sync[1];
  assign w_div_eff = (r_div < 32'd4) ? 32'd4 : r_div;
  assign w_expire  = (r_cnt == 32'd1);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], ser_rx};
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_div <= DIV_RESET;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (reg_div_we[i]) r_div[8*i +: 8] <= reg_div_di[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (!w_rx) w_state_next = StStart;
      StStart: if (w_expire) w_state_next = w_rx ? StIdle : StData;
      StData:  if (w_expire && (r_bit == 3'd7)) w_state_next = StStop;
      StStop: begin
        // After a framing error, hold here until the line returns high.
        if (r_brk) begin
          if (w_rx) w_state_next = StIdle;
        end else if (w_expire && w_rx) begin
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    w_push     = 1'b0;
    w_ferr_set = 1'b0;
    if ((r_state == StStop) && !r_brk && w_expire) begin
      w_push     = w_rx;
      w_ferr_set = !w_rx;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt     <= 32'd0;
      r_div_lat <= 32'd4;
      r_bit     <= 3'd0;
      r_shift   <= 8'd0;
      r_brk     <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (!w_rx) begin
            r_cnt     <= {1'b0, w_div_eff[31:1]};
            r_div_lat <= w_div_eff;
            r_bit     <= 3'd0;
          end
        end
        StStart: r_cnt <= w_expire ? r_div_lat : r_cnt - 32'd1;
        StData: begin
          if (w_expire) begin
            r_cnt   <= r_div_lat;
            r_shift <= {w_rx, r_shift[7:1]};
            r_bit   <= r_bit + 3'd1;
          end else begin
            r_cnt <= r_cnt - 32'd1;
          end
        end
        StStop: begin
          if (r_brk) begin
            if (w_rx) r_brk <= 1'b0;
          end else if (w_expire) begin
            r_brk <= !w_rx;
          end else begin
            r_cnt <= r_cnt - 32'd1;
          end
        end
        default: r_brk <= 1'b0;
      endcase
    end
  end

  assign w_rd      = reg_dat_re && !w_empty;
  assign w_wr      = w_push && (!w_full || w_rd);
  assign w_ovr_set = w_push && w_full && !w_rd;

`ifdef UART_RX_FIFO_EN
  localparam int unsigned Depth = 2 ** DEPTH_LOG2;

  logic [7:0]            r_mem [Depth];
  logic [DEPTH_LOG2-1:0] r_wptr, r_rptr;
  logic [CntW-1:0]       r_count;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CntW'(Depth));
  assign w_head  = r_mem[r_rptr];
  assign w_count = r_count;

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= r_shift;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_rd) r_rptr <= r_rptr + 1'b1;
      if (w_wr && !w_rd) begin
        r_count <= r_count + 1'b1;
      end else if (!w_wr && w_rd) begin
        r_count <= r_count - 1'b1;
      end
    end
  end
`else
  logic [7:0] r_hold;
  logic       r_valid;

  assign w_empty = !r_valid;
  assign w_full  = r_valid;
  assign w_head  = r_hold;
  assign w_count = CntW'(r_valid);

  always_ff @(posedge clk) begin
    if (w_wr) r_hold <= r_shift;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_valid <= 1'b0;
    end else if (w_wr) begin
      r_valid <= 1'b1;
    end else if (w_rd) begin
      r_valid <= 1'b0;
    end
  end
`endif

  // Setting a sticky flag takes priority over a same-cycle clear.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ovr  <= 1'b0;
      r_ferr <= 1'b0;
    end else begin
      r_ovr  <= w_ovr_set  | (r_ovr  & ~reg_sta_we);
      r_ferr <= w_ferr_set | (r_ferr & ~reg_sta_we);
    end
  end

  assign empty      = w_empty;
  assign reg_div_do = r_div;
  assign reg_dat_do = w_empty ? 32'hFFFF_FFFF : {24'h0, w_head};
  assign reg_sta_do = {16'h0, 8'(w_count), 4'h0, r_ferr, r_ovr, w_full, w_empty};

endmodule

// File: doc/uart_rx_buffer.md
UART_RX_BUFFER -- requirements
Module: uart_rx_buffer

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 4, log2 of receive FIFO depth (16 bytes).
REQ-002 SHALL have parameter DIV_RESET, default 32'd868, bit-period divider after reset (100 MHz / 115200).
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port resetn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port ser_rx  input  1  asynchronous serial line, idle high.
REQ-006 SHALL have port reg_div_we  input  4  byte write strobes, divider register.
REQ-007 SHALL have port reg_div_di  input  32  divider write data.
REQ-008 SHALL have port reg_div_do  output  32  current divider.
REQ-009 SHALL have port reg_dat_re  input  1  pop one byte from FIFO head.
REQ-010 SHALL have port reg_dat_do  output  32  {24'h0, head byte}; 32'hFFFF_FFFF when empty.
REQ-011 SHALL have port reg_sta_we  input  1  clear sticky error flags.
REQ-012 SHALL have port reg_sta_do  output  32  [0] empty, [1] full, [2] overrun, [3] frame error, [15:8] byte count, rest 0.
REQ-013 SHALL have port empty  output  1  FIFO holds no bytes.

Function
REQ-014 ser_rx SHALL pass through a 2-flop synchronizer (both flops reset to 1) before any use.
REQ-015 Receiver FSM SHALL have states IDLE, START, DATA, STOP; 8 data bits, LSB first, no parity, one stop bit.
REQ-016 IDLE->START on synchronized ser_rx == 0; bit counter loaded with divider/2.
REQ-017 START: on counter expiry, sample; 0 -> DATA with counter = divider; 1 -> IDLE (glitch, nothing pushed).
REQ-018 DATA: sample every divider clocks; after 8th sample -> STOP.
REQ-019 STOP: sample after divider clocks; 1 -> push byte, IDLE; 0 -> discard byte, set frame error, wait for line high, then IDLE.
REQ-020 Effective divider SHALL be max(divider, 4); values below 4 behave as 4; reg_div_do returns the written value unclamped.
REQ-021 Divider writes SHALL take effect at the next START; an in-flight frame uses the divider latched at START.
REQ-022 Pushed byte SHALL appear on reg_dat_do and deassert empty the cycle after the stop-bit sample.
REQ-023 reg_dat_do/reg_sta_do SHALL be combinational from current state; reg_dat_re pops on the rising edge where it is high.
REQ-024 Pop while empty SHALL be ignored; pointers and count unchanged.
REQ-025 Push while full and no simultaneous pop SHALL drop the new byte and set overrun; stored data unchanged.
REQ-026 Simultaneous push and pop when full SHALL accept both; count unchanged, no overrun.
REQ-027 Simultaneous push and pop when empty SHALL accept push, ignore pop; count becomes 1.
REQ-028 Read/write pointers SHALL wrap modulo 2^DEPTH_LOG2; count SHALL range 0..2^DEPTH_LOG2.
REQ-029 reg_sta_we SHALL clear overrun and frame error; a same-cycle set SHALL win over clear.

Reset
REQ-030 resetn low SHALL immediately force: FSM IDLE, pointers/count 0, empty 1, sticky flags 0, divider DIV_RESET, synchronizer 1.
REQ-031 Reset mid-frame SHALL abandon the frame; no partial byte pushed after release.
REQ-032 FIFO storage array SHALL NOT require reset; contents unobservable while empty.

Configuration
REQ-033 Macro UART_RX_FIFO_EN defined: FIFO depth 2^DEPTH_LOG2 per REQ-024..028.
REQ-034 UART_RX_FIFO_EN undefined: single-byte holding register; full == !empty; count field 0 or 1; DEPTH_LOG2 ignored; all other behaviour identical.

Verification
REQ-035 Divider 8, frame 0x55 on ser_rx -> empty falls after stop sample; reg_dat_do = 32'h0000_0055; reg_dat_re -> empty = 1, reg_dat_do = 32'hFFFF_FFFF.
REQ-036 Divider 8, 17 back-to-back frames 0x00..0x10, no pops -> count 16, full = 1, overrun = 1; pops return 0x00..0x0F in order.
REQ-037 1-clock low glitch on ser_rx at divider 8 -> no push, FSM back in IDLE, empty stays 1.
REQ-038 Frame 0xA3 with stop bit driven 0 -> no push, frame error = 1; reg_sta_we -> reg_sta_do[3] = 0.
REQ-039 Assert resetn low during data bit 4 of 0xC3, release -> empty = 1, divider = 868, no byte pushed.
REQ-040 FIFO full, pop coincident with stop-bit push of 0x7E -> count stays 16, overrun 0, 0x7E read last.
